// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter among NREQ requesters.
// A winner's byte is captured in IDLE (ack pulse), a start strobe (tx_dv) is
// issued, and the FSM then follows the transmitter's tx_active / tx_done flags
// until the transfer is complete (done pulse). A sticky err flag records the
// case where the transmitter never reports tx_active within TIMEOUT_CYC cycles.
//
// Handshake: req[i] is a level. The arbiter samples it only in IDLE, and
// ack[i] pulses for one cycle on the edge where the byte is captured. After
// ack the requester may drop req. Dropping req before ack cancels the request.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req[NREQ]          per-requester transmit request (level)
//   req_data[8*NREQ]   byte of requester i on [8i+7:8i]
//   ack[NREQ]          one-cycle pulse, byte of requester i captured
//   done[NREQ]         one-cycle pulse, byte of requester i fully transmitted
//   grant[NREQ]        one-hot transmitter owner, zero when idle
//   baud_cfg[8]        baud divider setting
//   count[8]           divider value driven to the transmitter
//   tx_dv              start strobe to the transmitter
//   data_byte[8]       byte to the transmitter
//   tx_active          transmitter active flag
//   tx_done            transmitter stop-bit flag
//   busy               high in every state except IDLE
//   err                sticky timeout flag
//   err_clr            synchronous clear of err (a same-cycle timeout wins)
//   dbg_state[3]       current FSM state, for observation only
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   grant,
  input  logic [7:0]        baud_cfg,
  output logic [7:0]        count,
  output logic              tx_dv,
  output logic [7:0]        data_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic [2:0]        dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACT  = 3'd2,
    WAIT_DONE = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state;
  logic [IW-1:0]   last_winner;
  logic [IW-1:0]   gnt_idx;
  logic [TW-1:0]   to_cnt;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [7:0]      win_data;

  // Round-robin search: the first set req bit at or after last_winner+1,
  // wrapping modulo NREQ.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_winner) + k) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    int base;
    base     = 8 * int'(win_idx);
    win_oh   = NREQ'(1) << win_idx;
    win_data = req_data[base +: 8];
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      ack         <= '0;
      done        <= '0;
      tx_dv       <= 1'b0;
      data_byte   <= '0;
      err         <= 1'b0;
      count       <= '0;
      last_winner <= IW'(NREQ - 1);
      gnt_idx     <= '0;
      to_cnt      <= '0;
    end else begin
      ack   <= '0;
      done  <= '0;
      tx_dv <= 1'b0;

      // The divider only follows baud_cfg between transfers.
      if (state == IDLE) count <= baud_cfg;

      // Clear first; a timeout assignment further down overrides it.
      if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          if (win_found) begin
            data_byte <= win_data;
            grant     <= win_oh;
            ack       <= win_oh;
            gnt_idx   <= win_idx;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Strobe is registered here, so it appears one cycle after ack.
          tx_dv  <= 1'b1;
          to_cnt <= '0;
          state  <= WAIT_ACT;
        end
        WAIT_ACT: begin
          if (tx_active) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            err         <= 1'b1;
            grant       <= '0;
            last_winner <= gnt_idx;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            done  <= grant;
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // Hold off the next start until the stop-bit flag has fallen.
          if (!tx_done) begin
            grant       <= '0;
            last_winner <= gnt_idx;
            state       <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack, done, grant;
  logic [7:0]        baud_cfg, count, data_byte;
  logic              tx_dv, tx_active, tx_done, busy, err, err_clr;
  logic [2:0]        dbg_state;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .grant(grant), .baud_cfg(baud_cfg),
    .count(count), .tx_dv(tx_dv), .data_byte(data_byte),
    .tx_active(tx_active), .tx_done(tx_done), .busy(busy),
    .err(err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: test did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int i);
    case (i)
      0: byte_of = 8'hA5;
      1: byte_of = 8'h22;
      2: byte_of = 8'h33;
      default: byte_of = 8'h44;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, ".grant"}, 32'(grant), 0);
    check({tag, ".ack"}, 32'(ack), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".tx_dv"}, 32'(tx_dv), 0);
    check({tag, ".data_byte"}, 32'(data_byte), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".err"}, 32'(err), 0);
    check({tag, ".count"}, 32'(count), 0);
  endtask

  // Called with the FSM in WAIT_ACT just after tx_dv was seen.
  task automatic finish_xfer(input logic [3:0] exp, input logic [7:0] b);
    tx_active = 1'b1;
    tick();                                   // -> WAIT_DONE
    check("wd.tx_dv", 32'(tx_dv), 0);
    tick();
    check("wd.data_byte", 32'(data_byte), 32'(b));
    check("wd.grant", 32'(grant), 32'(exp));
    check("wd.done", 32'(done), 0);
    tx_done = 1'b1;
    tick();                                   // -> WAIT_IDLE, done pulse
    check("done.pulse", 32'(done), 32'(exp));
    tick();                                   // tx_done still high
    check("wi.done", 32'(done), 0);
    check("wi.tx_dv", 32'(tx_dv), 0);
    check("wi.busy", 32'(busy), 1);
    check("wi.data_byte", 32'(data_byte), 32'(b));
    tx_done   = 1'b0;
    tx_active = 1'b0;
    tick();                                   // -> IDLE
    check("end.busy", 32'(busy), 0);
    check("end.grant", 32'(grant), 0);
  endtask

  // Called in IDLE with req already applied.
  task automatic do_xfer(input logic [3:0] exp, input logic [7:0] b, input bit drop);
    tick();
    check("arb.ack", 32'(ack), 32'(exp));
    check("arb.grant", 32'(grant), 32'(exp));
    check("arb.data_byte", 32'(data_byte), 32'(b));
    check("arb.busy", 32'(busy), 1);
    check("arb.tx_dv", 32'(tx_dv), 0);
    if (drop) req = '0;
    tick();
    check("issue.tx_dv", 32'(tx_dv), 1);
    check("issue.ack", 32'(ack), 0);
    finish_xfer(exp, b);
  endtask

  // Called in IDLE with req applied; transmitter never goes active.
  task automatic run_timeout(input logic [3:0] exp, input bit clr_same_cycle);
    tick();
    check("to.ack", 32'(ack), 32'(exp));
    req = '0;
    tick();
    check("to.tx_dv", 32'(tx_dv), 1);
    repeat (15) tick();
    check("to.err_early", 32'(err), 0);
    check("to.busy_early", 32'(busy), 1);
    if (clr_same_cycle) err_clr = 1'b1;
    tick();
    check("to.err", 32'(err), 1);
    check("to.busy", 32'(busy), 0);
    check("to.grant", 32'(grant), 0);
    check("to.done", 32'(done), 0);
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
    baud_cfg  = 8'd2;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    err_clr   = 1'b0;
    #3;
    check_reset("rst0");
    tick();
    rst_n = 1'b1;

    // Single request, requester 0
    req = 4'b0001;
    do_xfer(4'b0001, 8'hA5, 1'b1);
    check("s1.count", 32'(count), 2);

    // Fresh reset, then all requesters active: order 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) do_xfer(4'(1 << (i % 4)), byte_of(i % 4), 1'b0);
    req = '0;

    // Baud hold: requester 1 (last winner 0)
    baud_cfg = 8'd4;
    tick();
    check("baud.idle_load", 32'(count), 4);
    req = 4'b0010;
    tick();
    check("baud.ack", 32'(ack), 4'b0010);
    req = '0;
    tick();
    check("baud.tx_dv", 32'(tx_dv), 1);
    tx_active = 1'b1;
    tick();                                   // WAIT_DONE
    baud_cfg = 8'd9;
    tick();
    check("baud.hold_wd", 32'(count), 4);
    tx_done = 1'b1;
    tick();
    check("baud.done", 32'(done), 4'b0010);
    check("baud.hold_wi", 32'(count), 4);
    tx_done   = 1'b0;
    tx_active = 1'b0;
    tick();                                   // back in IDLE
    check("baud.hold_exit", 32'(count), 4);
    tick();
    check("baud.reload", 32'(count), 9);

    // Cancelled request: requester 1 pulses req only while busy
    req = 4'b0001;
    tick();
    check("cancel.ack0", 32'(ack), 4'b0001);
    req = 4'b0010;
    tick();
    check("cancel.ack", 32'(ack), 0);
    check("cancel.grant", 32'(grant), 4'b0001);
    check("cancel.tx_dv", 32'(tx_dv), 1);
    req = '0;
    finish_xfer(4'b0001, 8'hA5);
    tick();
    tick();
    check("cancel.idle_ack", 32'(ack), 0);
    check("cancel.idle_grant", 32'(grant), 0);

    // Timeout on requester 2, then requester 3 wins next
    req = 4'b0100;
    run_timeout(4'b0100, 1'b0);
    req = 4'b1111;
    tick();
    check("next.ack", 32'(ack), 4'b1000);
    check("next.data_byte", 32'(data_byte), 8'h44);
    check("next.err_sticky", 32'(err), 1);
    req = '0;
    err_clr = 1'b1;
    tick();
    check("next.err_clr", 32'(err), 0);
    check("next.tx_dv", 32'(tx_dv), 1);
    err_clr = 1'b0;
    finish_xfer(4'b1000, 8'h44);

    // Timeout coinciding with err_clr: set wins (requester 0)
    req = 4'b0001;
    run_timeout(4'b0001, 1'b1);

    // Reset during WAIT_DONE
    req = 4'b0001;
    tick();
    check("rmid.ack", 32'(ack), 4'b0001);
    req = '0;
    tick();
    tx_active = 1'b1;
    tick();
    check("rmid.busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset("rmid");
    tx_active = 1'b0;
    req = 4'b0100;
    tick();
    check("rmid.held_ack", 32'(ack), 0);
    rst_n = 1'b1;
    #1;
    check("rmid.release_ack", 32'(ack), 0);
    tick();
    check("rmid.win_ack", 32'(ack), 4'b0100);
    check("rmid.win_grant", 32'(grant), 4'b0100);
    check("rmid.win_byte", 32'(data_byte), 8'h33);
    req = '0;
    tick();
    check("rmid.tx_dv", 32'(tx_dv), 1);
    finish_xfer(4'b0100, 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
